// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encoding and constants for the debounce input stage
package debounce_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  // Accepted output level associated with a state.
  function automatic logic level_of(input state_t s);
    return (s == IDLE_HIGH) || (s == WAIT_LOW);
  endfunction

  function automatic logic busy_of(input state_t s);
    return (s == WAIT_HIGH) || (s == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer for asynchronous inputs
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizing debouncer with qualified level and edge strobes
// Optional edge strobes compiled in by DEBOUNCE_EDGE_PULSE_EN.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic busy,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit                ONE_SHOT = (STABLE_CYCLES == 1);

  logic             s2;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (s2)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE_LOW: if (s2) begin
        cnt_nx   = CNT_ONE;
        state_nx = ONE_SHOT ? IDLE_HIGH : WAIT_HIGH;
      end
      WAIT_HIGH: if (!s2) begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nx = IDLE_HIGH;
        cnt_nx   = '0;
      end else begin
        cnt_nx   = cnt + 1'b1;
      end
      IDLE_HIGH: if (!s2) begin
        cnt_nx   = CNT_ONE;
        state_nx = ONE_SHOT ? IDLE_LOW : WAIT_LOW;
      end
      WAIT_LOW: if (s2) begin
        state_nx = IDLE_HIGH;
        cnt_nx   = '0;
      end else if (cnt == CNT_LAST) begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end else begin
        cnt_nx   = cnt + 1'b1;
      end
      default: begin
        state_nx = IDLE_LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dout  <= level_of(state_nx);
      busy  <= busy_of(state_nx);
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= !dout && level_of(state_nx);
      fall_pulse <= dout && !level_of(state_nx);
    end
  end
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - self-checking bench for debounce_sync (STABLE_CYCLES=4 and 1)
module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic dout4, busy4, rise4, fall4;
  logic dout1, busy1, rise1, fall1;

  int checks = 0;
  int errors = 0;
  int busy1_seen = 0;

  always #5 clk = ~clk;

  debounce_sync #(.STABLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout4), .busy(busy4), .rise_pulse(rise4), .fall_pulse(fall4)
  );

  debounce_sync #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout1), .busy(busy1), .rise_pulse(rise1), .fall_pulse(fall1)
  );

  // Reference: a level is accepted once the twice-delayed input has differed
  // from the accepted level on STABLE_CYCLES consecutive edges.
  int   sc [2] = '{4, 1};
  logic hist [2];
  int   run [2];
  logic md [2], mb [2], mr [2], mf [2];

  task automatic model_reset();
    hist[0] = 1'b0; hist[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; md[i] = 1'b0; mb[i] = 1'b0; mr[i] = 1'b0; mf[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic seen;
    seen = hist[0];
    hist[0] = hist[1];
    hist[1] = din;
    for (int i = 0; i < 2; i++) begin
      run[i] = (seen != md[i]) ? run[i] + 1 : 0;
      mr[i] = 1'b0;
      mf[i] = 1'b0;
      if (run[i] == sc[i]) begin
        md[i] = ~md[i];
        mr[i] = md[i];
        mf[i] = ~md[i];
        run[i] = 0;
      end
      mb[i] = (run[i] != 0);
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (busy1) busy1_seen++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " dout4"}, dout4, md[0]);
    chk({tag, " busy4"}, busy4, mb[0]);
    chk({tag, " rise4"}, rise4, PE & mr[0]);
    chk({tag, " fall4"}, fall4, PE & mf[0]);
    chk({tag, " dout1"}, dout1, md[1]);
    chk({tag, " busy1"}, busy1, mb[1]);
    chk({tag, " rise1"}, rise1, PE & mr[1]);
    chk({tag, " fall1"}, fall1, PE & mf[1]);
  endtask

  typedef struct {
    logic dout;
    logic busy;
    logic rise;
    logic fall;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int nrise, nfall, hold;
    logic lvl;

    model_reset();
    #1;
    chk("reset dout", dout4, 1'b0);
    chk("reset busy", busy4, 1'b0);
    chk("reset rise", rise4, 1'b0);
    chk("reset fall", fall4, 1'b0);

    // din held high through reset release, STABLE_CYCLES=4
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, PE,   1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0};
    din = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk($sformatf("hold e%0d dout", k + 1), dout4, tbl[k].dout);
      chk($sformatf("hold e%0d busy", k + 1), busy4, tbl[k].busy);
      chk($sformatf("hold e%0d rise", k + 1), rise4, tbl[k].rise);
      chk($sformatf("hold e%0d fall", k + 1), fall4, tbl[k].fall);
      chk($sformatf("s1 e%0d dout", k + 1), dout1, (k + 1 >= 3));
    end

    // 3-cycle glitch
    din = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) cycle();
    din = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 3) din = 1'b0;
      chk($sformatf("glitch e%0d dout", k), dout4, 1'b0);
      chk($sformatf("glitch e%0d busy", k), busy4, (k >= 3 && k <= 5));
      chk($sformatf("glitch e%0d pulse", k), rise4 | fall4, 1'b0);
    end

    // press then release 20 cycles later
    do_reset();
    nrise = 0; nfall = 0;
    din = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      nrise += rise4; nfall += fall4;
      chk($sformatf("press e%0d dout", k), dout4, (k >= 6));
    end
    din = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      nrise += rise4; nfall += fall4;
      chk($sformatf("release e%0d dout", k), dout4, (k < 6));
    end
    chk("press rise count", nrise == int'(PE), 1'b1);
    chk("press fall count", nfall == int'(PE), 1'b1);

    // reset mid-qualification (cnt=2), between edges
    din = 1'b0;
    do_reset();
    din = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("pre-reset busy", busy4, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset dout", dout4, 1'b0);
    chk("midreset busy", busy4, 1'b0);
    chk("midreset pulse", rise4 | fall4, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      chk($sformatf("requal e%0d dout", k), dout4, (k >= 6));
    end

    // randomized run against the reference model
    lvl = 1'b0;
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) begin
        do_reset();
      end
      if (hold == 0) begin
        lvl = ~lvl;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(1, 5);
      end
      din = lvl;
      hold--;
      cycle();
      cmp_model("rand");
    end

    chk("s1 busy never", busy1_seen == 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000, range 1..1048576: consecutive synchronized cycles an input level must hold before it is accepted.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state rising-edge triggered.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din, input, 1 bit: raw asynchronous level input (switch/button).
REQ-005 SHALL have port dout, output, 1 bit: debounced, synchronized level. It feeds the d input of the downstream reset flip-flop stage.
REQ-006 SHALL have port busy, output, 1 bit: high while a candidate level change is being qualified.
REQ-007 SHALL have port rise_pulse, output, 1 bit: one-cycle strobe on an accepted 0->1 change.
REQ-008 SHALL have port fall_pulse, output, 1 bit: one-cycle strobe on an accepted 1->0 change.

Function
REQ-009 SHALL pass din through a 2-flop synchronizer (s1, s2). Only s2 is used by the downstream logic.
REQ-010 SHALL implement the FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH and WAIT_LOW.
REQ-011 SHALL have a counter of width CNT_W = clog2(STABLE_CYCLES+1), unsigned, that never wraps.
REQ-012 SHALL, in IDLE_LOW with s2=1, set cnt=1. If STABLE_CYCLES=1 it goes directly to IDLE_HIGH; otherwise it goes to WAIT_HIGH.
REQ-013 SHALL handle WAIT_HIGH as follows:
- s2=0: return to IDLE_LOW and clear cnt.
- s2=1 and cnt=STABLE_CYCLES-1: go to IDLE_HIGH.
- otherwise: increment cnt.
REQ-014 SHALL apply the mirror of REQ-012/013 for IDLE_HIGH and WAIT_LOW, with the s2 polarity inverted.
REQ-015 SHALL register dout: it is 1 exactly in IDLE_HIGH and WAIT_LOW.
REQ-016 SHALL register busy: it is 1 exactly in WAIT_HIGH and WAIT_LOW.
REQ-017 SHALL update dout exactly STABLE_CYCLES+2 clock edges after din settles, counting the first edge that samples the new din as edge 1.
REQ-018 SHALL assert rise_pulse (or fall_pulse) in the same cycle dout changes, for exactly one cycle. The two pulses are never high together.
REQ-019 SHALL leave dout unchanged and produce no pulse when a glitch is shorter than STABLE_CYCLES synchronized cycles.
REQ-020 SHALL restart qualification from cnt=1 when din reverses and re-reverses during a WAIT state.

Reset
REQ-021 SHALL, while rst_n=0, immediately force all of the following to 0, regardless of clk: s1, s2, cnt, dout, busy, rise_pulse, fall_pulse. The state SHALL be IDLE_LOW.
REQ-022 SHALL discard any partial count on reset mid-qualification. After release, full qualification is required again.
REQ-023 SHALL, after rst_n deasserts with din=1 held, raise dout only after the full REQ-017 latency.

Configuration
REQ-024 SHALL use the macro DEBOUNCE_EDGE_PULSE_EN to compile the edge-strobe logic in or out:
- Defined: rise_pulse and fall_pulse behave per REQ-018.
- Undefined: both ports remain present, are tied constant 0, and no pulse flops are generated.

Structure
REQ-025 SHALL define the FSM state enum (2-bit encoding) and the constant SYNC_STAGES=2 in shared package debounce_pkg.
REQ-026 SHALL implement the synchronizer as sub-module sync_2ff (ports clk, rst_n, d, q), reused by other input stages.

Verification
REQ-027 SHALL cover each scenario below, with STABLE_CYCLES=4 unless stated:
- din=1 held through reset release -> dout=0 for edges 1-5, dout=1 at edge 6; rise_pulse high for that one cycle only.
- 3-cycle din high glitch -> dout stays 0, no pulses; busy high for 3 cycles then 0.
- Clean press, then release 20 cycles later -> dout 1 at edge 6 and 0 at edge 6 after release; one rise_pulse and one fall_pulse.
- rst_n asserted mid-WAIT_HIGH (cnt=2), between clock edges -> dout, busy and pulses 0 immediately; after release with din=1, dout rises only after another 6 edges.
- DEBOUNCE_EDGE_PULSE_EN undefined, the press/release scenario rerun -> dout identical; rise_pulse and fall_pulse constant 0.
- STABLE_CYCLES=1, din 0->1 -> dout=1 at edge 3; busy never asserted.
